async_single_port_ram: RTL and testbench
========================================

# async_single_port_ram

Single-port RAM of DEPTH words × WIDTH bits with synchronous write and asynchronous (combinational) read through one shared address bus. It is the basic on-chip storage primitive for small scratch buffers and register-file-style tables. One clock; all locations are cleared by an asynchronous active-low reset.

## Interface
- WIDTH, default 8: data word width in bits.
- DEPTH, default 64: number of words.
- ADDR_BUS, default $clog2(DEPTH) (6): address width.

- clk  input  1  write clock; rising-edge active.
- rst  input  1  reset. Asynchronous and active-low; clears all memory locations.
- we  input  1  write enable. 1 = write mode; 0 = read mode.
- din  input  WIDTH  write data.
- addr  input  ADDR_BUS  word address, shared by write and read.
- dout  output  WIDTH  read data, always equal to mem[addr].

## Operation
- Storage: array of DEPTH words, each WIDTH bits, indexed 0 to DEPTH-1.
- Reset (rst = 0): every word is forced to 0 immediately, without waiting for a clock edge. The array holds at 0 while rst is low. Writes are ignored while rst is low.
- Write: on a rising clk edge with rst = 1 and we = 1, mem[addr] <= din. Only the addressed word changes.
- Read: dout = mem[addr], combinational. It is valid regardless of we and requires no clock.
- we = 0: no location is modified. Read mode needs no other action.
- Address range is 0..DEPTH-1. With default parameters, all 2^ADDR_BUS codes are valid, so there is no out-of-range case.
- For a non-power-of-two DEPTH:
  - Writes to addresses ≥ DEPTH are dropped.
  - Reads of those addresses return 0.
- Rewriting an address overwrites the old value. There is no write protection and no byte enables.
- There is no X-propagation guard. Contents before the first reset are undefined, but any read after reset returns a defined value.

## Timing
- Write latency: the new data is visible on dout in the same cycle, immediately after the clk edge that performs the write, as long as addr is still held.
- Read latency: zero cycles. dout follows addr and memory changes combinationally.
- Read-during-write to the same address:
  - Before the edge, dout shows the old content.
  - After the edge, dout shows din (write-first after the edge).
- Reset assertion takes effect asynchronously: dout = 0 as soon as rst falls, for any addr.
- Reset release is synchronous to no edge. The first write occurs at the first rising clk edge with rst = 1 and we = 1.
- Reset asserted in the middle of a write sequence:
  - All prior writes are lost.
  - A write edge coincident with rst = 0 does not occur.
- Stimulus convention: inputs change just after a rising edge and are sampled on the next rising edge.

## Test plan
- Reset clear: pulse rst low for one cycle, then read addresses 0, 1, 0x20 and 0x3F with we = 0 -> dout = 0x00 for each.
- Basic write/read: write 0x11@0x01, 0x22@0x02, 0x33@0x04, 0x44@0x08, then read those addresses with we = 0 -> 0x11, 0x22, 0x33, 0x44.
- Overwrite:
  - Write 0x44@0x10 and 0x44@0x20.
  - Later write 0x55@0x10 and 0x66@0x20.
  - Read -> 0x55 and 0x66.
  - Neighbours 0x11–0x13 and 0x21–0x22 still read 0x44.
- Read mode does not write: set we = 0, change din to 0xAA and sweep addr over written locations -> contents unchanged and dout matches the stored values combinationally, with no clock delay.
- Read-during-write: hold addr = 0x05 (stored 0x00), we = 1, din = 0x5A:
  - dout = 0x00 before the edge.
  - dout = 0x5A immediately after the edge.
- Async reset mid-operation:
  - After filling 0x00 and 0x3F with 0xFF, drop rst between clock edges.
  - dout goes to 0x00 without a clk edge.
  - After release, reads of 0x00 and 0x3F return 0x00.

Source files
------------

// File: rtl/async_single_port_ram.sv
// Single-port RAM: clocked write, combinational read on a shared address.
// All words clear asynchronously while rst is low.
module async_single_port_ram #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int ADDR_BUS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [WIDTH-1:0]    din,
    input  logic [ADDR_BUS-1:0] addr,
    output logic [WIDTH-1:0]    dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_in_range;

    // Only a non-power-of-two depth leaves address codes without storage.
    generate
        if (DEPTH >= (2 ** ADDR_BUS)) begin : g_full
            assign w_in_range = 1'b1;
        end else begin : g_partial
            localparam logic [ADDR_BUS-1:0] LP_LAST = ADDR_BUS'(DEPTH - 1);
            assign w_in_range = (addr <= LP_LAST);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && w_in_range) begin
            r_mem[addr] <= din;
        end
    end

    assign dout = w_in_range ? r_mem[addr] : '0;

endmodule

// File: tb/tb_async_single_port_ram.sv
// Directed bench for async_single_port_ram: reset clear, write/read,
// overwrite, read mode, read-during-write and mid-run async reset.
module tb_async_single_port_ram;

    logic       clk;
    logic       rst;
    logic       we;
    logic [7:0] din;
    logic [5:0] addr;
    logic [7:0] dout;

    int n_vec;
    int n_err;

    async_single_port_ram dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .din  (din),
        .addr (addr),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [5:0] a,
                      input logic [7:0] exp);
        addr = a;
        #1;
        chk(tag, dout, exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        we    = 1'b0;
        din   = 8'h00;
        addr  = 6'h00;

        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        rd("rst_00", 6'h00, 8'h00);
        rd("rst_01", 6'h01, 8'h00);
        rd("rst_20", 6'h20, 8'h00);
        rd("rst_3f", 6'h3F, 8'h00);

        wr(6'h01, 8'h11);
        wr(6'h02, 8'h22);
        wr(6'h04, 8'h33);
        wr(6'h08, 8'h44);
        rd("rd_01", 6'h01, 8'h11);
        rd("rd_02", 6'h02, 8'h22);
        rd("rd_04", 6'h04, 8'h33);
        rd("rd_08", 6'h08, 8'h44);
        rd("rd_03", 6'h03, 8'h00);

        wr(6'h10, 8'h44);
        wr(6'h11, 8'h44);
        wr(6'h12, 8'h44);
        wr(6'h13, 8'h44);
        wr(6'h20, 8'h44);
        wr(6'h21, 8'h44);
        wr(6'h22, 8'h44);
        wr(6'h10, 8'h55);
        wr(6'h20, 8'h66);
        rd("ow_10", 6'h10, 8'h55);
        rd("ow_20", 6'h20, 8'h66);
        rd("nb_11", 6'h11, 8'h44);
        rd("nb_12", 6'h12, 8'h44);
        rd("nb_13", 6'h13, 8'h44);
        rd("nb_21", 6'h21, 8'h44);
        rd("nb_22", 6'h22, 8'h44);

        // Read mode with junk on din across several clock edges.
        @(negedge clk);
        we  = 1'b0;
        din = 8'hAA;
        rd("rm_01", 6'h01, 8'h11);
        rd("rm_02", 6'h02, 8'h22);
        rd("rm_04", 6'h04, 8'h33);
        rd("rm_08", 6'h08, 8'h44);
        repeat (2) @(posedge clk);
        #1;
        rd("rm2_01", 6'h01, 8'h11);
        rd("rm2_10", 6'h10, 8'h55);
        rd("rm2_aa", 6'h05, 8'h00);

        @(negedge clk);
        addr = 6'h05;
        din  = 8'h5A;
        we   = 1'b1;
        #1 chk("rdw_pre", dout, 8'h00);
        @(posedge clk);
        #1 chk("rdw_post", dout, 8'h5A);
        we = 1'b0;

        wr(6'h00, 8'hFF);
        wr(6'h3F, 8'hFF);
        rd("ff_00", 6'h00, 8'hFF);
        rd("ff_3f", 6'h3F, 8'hFF);

        @(negedge clk);
        #1 rst = 1'b0;
        #1 chk("arst_3f", dout, 8'h00);
        rd("arst_00", 6'h00, 8'h00);

        din = 8'h77;
        we  = 1'b1;
        @(posedge clk);
        #1 chk("rst_wr", dout, 8'h00);
        we  = 1'b0;
        rst = 1'b1;

        rd("post_00", 6'h00, 8'h00);
        rd("post_3f", 6'h3F, 8'h00);
        rd("post_10", 6'h10, 8'h00);
        rd("post_05", 6'h05, 8'h00);

        wr(6'h2A, 8'hC3);
        rd("rel_2a", 6'h2A, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
